// File: rtl/tlc_multi_phase_if.sv
// Signal bundle between the intersection controller and its environment.
// master = environment (drives requests, reads lamps); slave = controller.
interface tlc_multi_phase_if #(
  parameter int N_APPR = 4,
  parameter int PW     = (N_APPR > 1) ? $clog2(N_APPR) : 1
);
  logic                  en;
  logic [N_APPR-1:0]     demand;
  logic                  emerg;
  logic [PW-1:0]         emerg_sel;
  logic [3*N_APPR-1:0]   lights;
  logic [PW-1:0]         cur_phase;
  logic [1:0]            fsm_state;
  logic                  preempt;

  modport master (
    output en, demand, emerg, emerg_sel,
    input  lights, cur_phase, fsm_state, preempt
  );

  modport slave (
    input  en, demand, emerg, emerg_sel,
    output lights, cur_phase, fsm_state, preempt
  );
endinterface

// File: rtl/tlc_multi_phase.sv
// N-approach traffic light controller: round-robin green rotation with
// demand skipping, programmable green/yellow/all-red times and emergency
// pre-emption. All outputs are decoded directly from the state registers.
module tlc_multi_phase #(
  parameter int N_APPR = 4,
  parameter int TG     = 12,
  parameter int TY     = 3,
  parameter int TAR    = 1
) (
  input  logic              clk,
  input  logic              rst,
  tlc_multi_phase_if.slave  bus
);
  localparam int PW   = (N_APPR > 1) ? $clog2(N_APPR) : 1;
  localparam int PW1  = PW + 1;
  localparam int TMAX = (TG > TY) ? ((TG > TAR) ? TG : TAR) : ((TY > TAR) ? TY : TAR);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [TW-1:0] TG_LD  = TW'(TG - 1);
  localparam logic [TW-1:0] TY_LD  = TW'(TY - 1);
  localparam logic [TW-1:0] TAR_LD = TW'((TAR > 0) ? TAR - 1 : 0);
  localparam logic [PW:0]   N_LIM  = PW1'(N_APPR);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            preempt_q, preempt_d;

  logic            emerg_ok;
  logic [PW-1:0]   next_norm;
  logic [PW-1:0]   next_phase;
  logic [2:0]      owner_lamp;
  int              idx;

  // An emergency target outside the approach range is treated as no request.
  assign emerg_ok = bus.emerg && ({1'b0, bus.emerg_sel} < N_LIM);

  // Demand-driven successor: nearest demanding approach after the owner,
  // the owner itself only if nobody else wants it, plain +1 if nobody does.
  always_comb begin
    next_norm = PW'((int'(phase_q) + 1) % N_APPR);
    idx       = 0;
    for (int k = N_APPR; k >= 1; k--) begin
      idx = (int'(phase_q) + k) % N_APPR;
      if (bus.demand[PW'(idx)]) next_norm = PW'(idx);
    end
  end

  assign next_phase = emerg_ok ? bus.emerg_sel : next_norm;

  // Next-state logic: timer counts down, zero at an enabled edge means leave.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    preempt_d = preempt_q;
    if (bus.en) begin
      preempt_d = emerg_ok;
      case (state_q)
        S_GREEN: begin
          if (emerg_ok && (bus.emerg_sel == phase_q)) begin
            timer_d = TG_LD;                 // hold the pre-empted green
          end else if (emerg_ok || (timer_q == '0)) begin
            state_d = S_YELLOW;
            timer_d = TY_LD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_YELLOW: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (TAR > 0) begin
            state_d = S_ALLRED;
            timer_d = TAR_LD;
          end else begin
            state_d = S_GREEN;
            phase_d = next_phase;
            timer_d = TG_LD;
          end
        end
        S_ALLRED: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else begin
            state_d = S_GREEN;
            phase_d = next_phase;
            timer_d = TG_LD;
          end
        end
        default: begin
          state_d = S_GREEN;
          phase_d = '0;
          timer_d = TG_LD;
        end
      endcase
    end
  end

  // State registers with asynchronous return to approach 0 green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_GREEN;
      phase_q   <= '0;
      timer_q   <= TG_LD;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      preempt_q <= preempt_d;
    end
  end

  // Lamp pattern shown by the owning approach.
  always_comb begin
    owner_lamp = 3'b100;
    case (state_q)
      S_GREEN:  owner_lamp = 3'b001;
      S_YELLOW: owner_lamp = 3'b010;
      default:  owner_lamp = 3'b100;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_APPR; gi++) begin : g_lamp
      assign bus.lights[3*gi +: 3] = (phase_q == PW'(gi)) ? owner_lamp : 3'b100;
    end
  endgenerate

  assign bus.cur_phase = phase_q;
  assign bus.fsm_state = state_q;
  assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_tlc_multi_phase.sv
// Bench for tlc_multi_phase: a default 4-approach build and a 3-approach
// build without all-red, both driven from shared stimulus and compared each
// cycle against a segment/elapsed-count reference model.
module tb_tlc_multi_phase;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_r  = 1'b0;
  logic [3:0] dem_r = 4'hF;
  logic       em_r  = 1'b0;
  logic [1:0] sel_r = 2'd0;

  tlc_multi_phase_if #(.N_APPR(4)) bus0 ();
  tlc_multi_phase_if #(.N_APPR(3)) bus1 ();

  assign bus0.en = en_r;  assign bus0.demand = dem_r;       assign bus0.emerg = em_r;  assign bus0.emerg_sel = sel_r;
  assign bus1.en = en_r;  assign bus1.demand = dem_r[2:0];  assign bus1.emerg = em_r;  assign bus1.emerg_sel = sel_r;

  tlc_multi_phase #(.N_APPR(4), .TG(12), .TY(3), .TAR(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tlc_multi_phase #(.N_APPR(3), .TG(4),  .TY(2), .TAR(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: owner p, segment seg (0 green,1 yellow,2 all-red),
  // el = enabled cycles already spent in the segment.
  int n_a[2]   = '{4, 3};
  int tg_a[2]  = '{12, 4};
  int ty_a[2]  = '{3, 2};
  int tar_a[2] = '{1, 0};
  int p[2], seg[2], el[2];
  bit pre[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      p[m] = 0; seg[m] = 0; el[m] = 0; pre[m] = 1'b0;
    end
  endtask

  function automatic int pick(int m, bit ev);
    if (ev) return int'(sel_r);
    for (int k = 1; k <= n_a[m]; k++)
      if (dem_r[(p[m] + k) % n_a[m]]) return (p[m] + k) % n_a[m];
    return (p[m] + 1) % n_a[m];
  endfunction

  task automatic model_step(int m);
    bit ev;
    if (!en_r) return;
    ev = em_r && (int'(sel_r) < n_a[m]);
    case (seg[m])
      0: begin
        if (ev && int'(sel_r) == p[m]) el[m] = 0;
        else if (ev || el[m] + 1 >= tg_a[m]) begin seg[m] = 1; el[m] = 0; end
        else el[m]++;
      end
      1: begin
        if (el[m] + 1 >= ty_a[m]) begin
          if (tar_a[m] > 0) begin seg[m] = 2; el[m] = 0; end
          else begin p[m] = pick(m, ev); seg[m] = 0; el[m] = 0; end
        end else el[m]++;
      end
      default: begin
        if (el[m] + 1 >= tar_a[m]) begin p[m] = pick(m, ev); seg[m] = 0; el[m] = 0; end
        else el[m]++;
      end
    endcase
    pre[m] = ev;
  endtask

  function automatic logic [16:0] exp_vec(int m);
    logic [11:0] l;
    logic [2:0]  own;
    l   = '0;
    own = (seg[m] == 0) ? 3'b001 : (seg[m] == 1) ? 3'b010 : 3'b100;
    for (int i = 0; i < n_a[m]; i++) l[3*i +: 3] = (i == p[m]) ? own : 3'b100;
    return {l, 2'(p[m]), 2'(seg[m]), pre[m]};
  endfunction

  function automatic logic [16:0] act0();
    return {bus0.lights, bus0.cur_phase, bus0.fsm_state, bus0.preempt};
  endfunction

  function automatic logic [16:0] act1();
    return {3'b000, bus1.lights, bus1.cur_phase, bus1.fsm_state, bus1.preempt};
  endfunction

  // One clock: inputs already stable since the previous falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    en_r = 1'b1; dem_r = 4'hF; em_r = 1'b0; sel_r = 2'd0;
    do_reset();
    n_checks++;
    if (bus0.lights !== 12'b100_100_100_001 || bus0.cur_phase !== 2'd0 || bus0.fsm_state !== 2'd0 || bus0.preempt !== 1'b0) begin
      n_err++; $display("FAIL reset4: got %b/%0d/%0d/%b exp 100100100001/0/0/0", bus0.lights, bus0.cur_phase, bus0.fsm_state, bus0.preempt);
    end
    n_checks++;
    if (bus1.lights !== 9'b100_100_001 || bus1.cur_phase !== 2'd0 || bus1.preempt !== 1'b0) begin
      n_err++; $display("FAIL reset3: got %b/%0d/%b exp 100100001/0/0", bus1.lights, bus1.cur_phase, bus1.preempt);
    end
    $display("test_reset: done");
  endtask

  task automatic test_fixed_cycle();
    dem_r = 4'hF; em_r = 1'b0; en_r = 1'b1;
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      tick();
      n_checks++;
      if (act0() !== exp_vec(0)) begin n_err++; $display("FAIL cycle c=%0d: got %b exp %b", c, act0(), exp_vec(0)); end
      n_checks++;
      if (act1() !== exp_vec(1)) begin n_err++; $display("FAIL cycle3 c=%0d: got %b exp %b", c, act1(), exp_vec(1)); end
      if (c == 11 || c == 12 || c == 15 || c == 16 || c == 63 || c == 64) begin
        logic [3:0] want;
        want = (c == 11) ? 4'b00_00 : (c == 12) ? 4'b00_01 : (c == 15) ? 4'b00_10 :
               (c == 16) ? 4'b01_00 : (c == 63) ? 4'b11_10 : 4'b00_00;
        n_checks++;
        if ({bus0.cur_phase, bus0.fsm_state} !== want) begin
          n_err++; $display("FAIL timing c=%0d: got phase/state %b exp %b", c, {bus0.cur_phase, bus0.fsm_state}, want);
        end
      end
    end
    $display("test_fixed_cycle: done");
  endtask

  task automatic test_demand_skip();
    dem_r = 4'b1000; em_r = 1'b0; en_r = 1'b1;
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      if (c == 33) dem_r = 4'b0000;
      tick();
      n_checks++;
      if (act0() !== exp_vec(0)) begin n_err++; $display("FAIL skip c=%0d: got %b exp %b", c, act0(), exp_vec(0)); end
      if (c == 16 || c == 32 || c == 48 || c == 64) begin
        logic [1:0] want;
        want = (c == 16 || c == 32) ? 2'd3 : (c == 48) ? 2'd0 : 2'd1;
        n_checks++;
        if (bus0.cur_phase !== want || bus0.fsm_state !== 2'd0) begin
          n_err++; $display("FAIL skip_order c=%0d: got phase %0d state %0d exp phase %0d state 0", c, bus0.cur_phase, bus0.fsm_state, want);
        end
      end
    end
    $display("test_demand_skip: done");
  endtask

  task automatic test_emergency();
    dem_r = 4'hF; em_r = 1'b0; en_r = 1'b1; sel_r = 2'd0;
    do_reset();
    for (int c = 1; c <= 70; c++) begin
      if (c == 6)  begin em_r = 1'b1; sel_r = 2'd2; end
      if (c == 31) em_r = 1'b0;
      tick();
      n_checks++;
      if (act0() !== exp_vec(0)) begin n_err++; $display("FAIL emerg c=%0d: got %b exp %b", c, act0(), exp_vec(0)); end
      n_checks++;
      if (act1() !== exp_vec(1)) begin n_err++; $display("FAIL emerg3 c=%0d: got %b exp %b", c, act1(), exp_vec(1)); end
      if (c == 6 || c == 9 || c == 10 || c == 30 || c == 41 || c == 42 || c == 46) begin
        logic [4:0] want;
        want = (c == 6)  ? 5'b00_01_1 : (c == 9)  ? 5'b00_10_1 : (c == 10) ? 5'b10_00_1 :
               (c == 30) ? 5'b10_00_1 : (c == 41) ? 5'b10_00_0 : (c == 42) ? 5'b10_01_0 : 5'b11_00_0;
        n_checks++;
        if ({bus0.cur_phase, bus0.fsm_state, bus0.preempt} !== want) begin
          n_err++; $display("FAIL emerg_seq c=%0d: got %b exp %b", c, {bus0.cur_phase, bus0.fsm_state, bus0.preempt}, want);
        end
      end
    end
    $display("test_emergency: done");
  endtask

  task automatic test_invalid_sel();
    dem_r = 4'hF; en_r = 1'b1; em_r = 1'b0;
    do_reset();
    em_r = 1'b1; sel_r = 2'd3;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_checks++;
      if (bus1.preempt !== 1'b0 || act1() !== exp_vec(1)) begin
        n_err++; $display("FAIL invalid_sel c=%0d: got %b exp %b", c, act1(), exp_vec(1));
      end
    end
    em_r = 1'b0;
    $display("test_invalid_sel: done");
  endtask

  task automatic test_freeze();
    dem_r = 4'hF; em_r = 1'b0; en_r = 1'b1;
    do_reset();
    for (int c = 0; c < 13; c++) tick();
    en_r = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin em_r = 1'b1; sel_r = 2'd1; dem_r = 4'b0100; end
      tick();
      n_checks++;
      if (bus0.fsm_state !== 2'd1 || bus0.cur_phase !== 2'd0 || bus0.preempt !== 1'b0 || act0() !== exp_vec(0)) begin
        n_err++; $display("FAIL freeze c=%0d: got %b exp %b", c, act0(), exp_vec(0));
      end
    end
    em_r = 1'b0; dem_r = 4'hF; en_r = 1'b1;
    tick();
    n_checks++;
    if (bus0.fsm_state !== 2'd1) begin n_err++; $display("FAIL freeze_resume1: got state %0d exp 1", bus0.fsm_state); end
    tick();
    n_checks++;
    if (bus0.fsm_state !== 2'd2) begin n_err++; $display("FAIL freeze_resume2: got state %0d exp 2", bus0.fsm_state); end
    $display("test_freeze: done");
  endtask

  task automatic test_async_reset();
    bit found;
    dem_r = 4'hF; em_r = 1'b0; en_r = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus0.fsm_state === 2'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_err++; $display("FAIL allred_timeout: got no ALLRED in 40 cycles exp ALLRED");
    end else begin
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus0.lights !== 12'b100_100_100_001 || bus0.fsm_state !== 2'd0 || bus0.cur_phase !== 2'd0) begin
        n_err++; $display("FAIL async_reset: got %b/%0d/%0d exp 100100100001/0/0", bus0.lights, bus0.cur_phase, bus0.fsm_state);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
    end
    $display("test_async_reset: done");
  endtask

  task automatic test_random();
    logic [11:0] prev_l;
    int nonred;
    do_reset();
    prev_l = bus0.lights;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(7) == 0)  dem_r = 4'($urandom);
      if ($urandom_range(19) == 0) em_r  = ~em_r;
      if ($urandom_range(29) == 0) sel_r = 2'($urandom);
      en_r = ($urandom_range(9) != 0);
      tick();
      n_checks++;
      if (act0() !== exp_vec(0)) begin n_err++; $display("FAIL rand c=%0d: got %b exp %b", c, act0(), exp_vec(0)); end
      n_checks++;
      if (act1() !== exp_vec(1)) begin n_err++; $display("FAIL rand3 c=%0d: got %b exp %b", c, act1(), exp_vec(1)); end
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus0.lights[3*i +: 3] !== 3'b100) nonred++;
        n_checks++;
        if (prev_l[3*i +: 3] === 3'b001 && bus0.lights[3*i +: 3] === 3'b100) begin
          n_err++; $display("FAIL green_to_red c=%0d lamp %0d: got 100 exp 001 or 010", c, i);
        end
      end
      n_checks++;
      if (nonred > 1) begin n_err++; $display("FAIL one_owner c=%0d: got %0d non-red exp <=1", c, nonred); end
      n_checks++;
      if (bus1.fsm_state === 2'd2) begin n_err++; $display("FAIL tar0_allred c=%0d: got state 2 exp 0 or 1", c); end
      prev_l = bus0.lights;
    end
    $display("test_random: done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_cycle();
    test_demand_skip();
    test_emergency();
    test_invalid_sel();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
